// File: rtl/gcd_if.sv
// Operand/result handshake bundle between an operand source and the GCD engine.
// The master drives start and operands; the slave returns status and result.
interface gcd_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH-1:0] step_cnt;
  logic             err;

  modport master (
    output start, a_in, b_in,
    input  busy, done, gcd_out, step_cnt, err
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, gcd_out, step_cnt, err
  );
endinterface

// File: rtl/gcd_engine.sv
// Iterative compare-and-subtract GCD engine, one subtraction per clock,
// with a saturating step counter and a both-operands-zero error flag.
module gcd_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  gcd_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] cnt_inc;

  // Saturate rather than wrap so long runs still report a meaningful bound.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (a_q == '0 && b_q == '0) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = StDone;
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = StDone;
        end else if (a_q > b_q) begin
          a_d   = a_q - b_q;
          cnt_d = cnt_inc;
        end else if (a_q < b_q) begin
          b_d   = b_q - a_q;
          cnt_d = cnt_inc;
        end else begin
          gcd_d   = a_q;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.gcd_out  = gcd_q;
  assign bus.step_cnt = cnt_q;
  assign bus.err      = err_q;

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Iterative, parametrised greatest-common-divisor engine built on the team's magnitude-compare datapath. It accepts two unsigned WIDTH-bit operands through a start/busy/done handshake. It computes their GCD by repeated compare-and-subtract, one step per clock, and reports the result, a subtraction-step count, and a zero-operand error flag. It is the sequential top of the GCD design and sits between the operand source and the result consumer.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  request; sampled only in IDLE or DONE
- a_in  in  WIDTH  operand A, unsigned, captured on accepted start
- b_in  in  WIDTH  operand B, unsigned, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- gcd_out  out  WIDTH  result; held from done until next accepted start
- step_cnt  out  WIDTH  subtractions performed; saturates at all-ones
- err  out  1  both operands were zero; valid with done, held like gcd_out

## Operation
- Reset value of all state and outputs on rst_n=0 at an edge:
  - state=IDLE
  - busy=0, done=0, gcd_out=0, step_cnt=0, err=0
  - internal A=0, B=0
- States: IDLE, RUN, DONE.
- IDLE:
  - With start=1: A<=a_in, B<=b_in, step_cnt<=0, err<=0, next state RUN.
  - Otherwise stay.
- RUN (one decision per cycle, checked in this priority order):
  - A==0 and B==0: gcd_out<=0, err<=1, go to DONE.
  - A==0: gcd_out<=B, go to DONE.
  - B==0: gcd_out<=A, go to DONE.
  - A>B: A<=A-B, step_cnt++, stay.
  - A<B: B<=B-A, step_cnt++, stay.
  - A==B: gcd_out<=A, go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - With start=1: capture new operands as in IDLE and go to RUN (back-to-back service).
  - Otherwise go to IDLE.
- Subtractions are unsigned WIDTH-bit. The larger value is always the minuend, so no underflow occurs.
- A zero operand can only appear on the first RUN cycle.
- step_cnt increments only on subtract cycles and saturates at 2^WIDTH-1 (no wrap). gcd_out stays correct regardless of saturation.
- start is ignored while in RUN. a_in/b_in are don't-care except on an accepted start.
- gcd_out/err are not cleared on start; they are overwritten when the next run finishes.

## Timing
- Accepted start at edge E0 → busy=1 from E0 until the edge ending RUN.
- With S subtraction steps, RUN lasts S+1 cycles. The DONE transition occurs at edge E(S+1).
- done is high in the cycle following edge E(S+1), and gcd_out/err/step_cnt are valid in that same cycle.
- Minimum latency (equal or zero operands): done in the 2nd cycle after the start edge.
- Worst case S = 2^WIDTH-2 (operands 2^WIDTH-1 and 1).
- busy and done are never high together.
- Back-to-back runs: with start held in DONE, busy returns the next cycle, so there is no idle gap.
- rst_n=0 during RUN or DONE aborts the operation at that edge. No done pulse follows, and all outputs take reset values.

## Test plan
- Reset, then start with a=12, b=18 → S=2, done 4 cycles after the start edge, gcd_out=6, step_cnt=2, err=0.
- a=b=45 → done in the 2nd cycle after start, gcd_out=45, step_cnt=0; then a=0, b=7 → gcd_out=7, step_cnt=0, err=0.
- a=0, b=0 → gcd_out=0, err=1; the next run with a=9, b=6 → gcd_out=3, step_cnt=2, err=0.
- WIDTH=8, a=255, b=1 → step_cnt=254, gcd_out=1, busy high for 255 cycles. Also pulse start mid-run and check it has no effect.
- Hold start high in DONE with new operands a=35, b=21 → busy rises the cycle after done with no IDLE cycle; result gcd_out=7, step_cnt=3.
- Assert rst_n=0 mid-RUN → no done, all outputs 0 after that edge; a following start with a=8, b=12 yields gcd_out=4.
